// File: rtl/clock_pkg.sv
// Shared types and helpers for the wall clock: alarm FSM states, BCD limits,
// and the 24h -> 12h display mapping.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING
  } alarm_state_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // Returns {pm, hh12}; pm follows the 24h value so it is valid in either mode.
  function automatic logic [8:0] to_12h(input logic [7:0] hh);
    logic [4:0] bin;
    logic [4:0] adj;
    logic [8:0] r;
    bin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    adj = bin - 5'd12;
    if (bin == 5'd0)
      r = {1'b0, 8'h12};
    else if (bin < 5'd12)
      r = {1'b0, hh};
    else if (bin == 5'd12)
      r = {1'b1, 8'h12};
    else if (adj >= 5'd10)
      r = {1'b1, 4'h1, 4'(adj - 5'd10)};
    else
      r = {1'b1, 4'h0, adj[3:0]};
    return r;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD register counting 00..MAX with synchronous clear and wrap carry.
// Next value is exported so callers can compare against the post-update count.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX     = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic [7:0] nxt,
  output logic       carry
);

  always_comb begin
    nxt   = value;
    carry = 1'b0;
    if (clr) begin
      nxt = 8'h00;
    end else if (inc) begin
      if (value == MAX) begin
        nxt   = 8'h00;
        carry = 1'b1;
      end else if (value[3:0] == 4'h9) begin
        nxt = {value[7:4] + 4'h1, 4'h0};
      end else begin
        nxt = {value[7:4], value[3:0] + 4'h1};
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset)
      value <= RST_VAL;
    else
      value <= nxt;
  end

endmodule

// File: rtl/wall_clock_core.sv
// Time-of-day engine: prescaled BCD hh:mm:ss, manual set, 12/24h display, one alarm.
// Display is registered (1 cycle after state); inputs are level/pulse, no backpressure.
module wall_clock_core
  import clock_pkg::*;
#(
  parameter int         TICKS_PER_SEC    = 100000000,
  parameter int         RING_SECS        = 60,
  parameter logic [7:0] ALARM_DEFAULT_HH = 8'h00,
  parameter logic [7:0] ALARM_DEFAULT_MM = 8'h00
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       run_en,
  input  logic       mode_12h,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       alarm_set,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic [7:0] hours_bcd,
  output logic [7:0] mins_bcd,
  output logic [7:0] secs_bcd,
  output logic       pm,
  output logic       sec_pulse,
  output logic       alarm_ring
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          time_edit;
  logic          tick;

  logic [7:0] secs, mins, hours, al_mm, al_hh;
  logic [7:0] secs_nxt, mins_nxt, hours_nxt, al_mm_nxt, al_hh_nxt;
  logic       secs_wrap, mins_wrap, hours_wrap, al_mm_wrap, al_hh_wrap;

  alarm_state_t alarm_state, state_nxt;
  logic [7:0]   ring_cnt, ring_cnt_nxt, ring_cnt_inc;
  logic         alarm_hit;

  logic [7:0] src_hh, src_mm, src_ss;
  logic [8:0] h12;

  // A time edit restarts the second and swallows any coincident tick.
  assign time_edit = !alarm_set && (inc_min || inc_hour);
  assign sec_pulse = run_en && (presc == TERM);
  assign tick      = sec_pulse && !time_edit;

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset)
      presc <= '0;
    else if (time_edit)
      presc <= '0;
    else if (run_en)
      presc <= (presc == TERM) ? '0 : presc + PW'(1);
  end

  bcd2_counter #(.MAX(SEC_MAX), .RST_VAL(8'h00)) u_secs (
    .CLK100MHZ (CLK100MHZ),
    .Reset     (Reset),
    .inc       (tick),
    .clr       (time_edit),
    .value     (secs),
    .nxt       (secs_nxt),
    .carry     (secs_wrap)
  );

  bcd2_counter #(.MAX(MIN_MAX), .RST_VAL(8'h00)) u_mins (
    .CLK100MHZ (CLK100MHZ),
    .Reset     (Reset),
    .inc       ((!alarm_set && inc_min) || secs_wrap),
    .clr       (1'b0),
    .value     (mins),
    .nxt       (mins_nxt),
    .carry     (mins_wrap)
  );

  // Only a tick-driven minute wrap carries; a manual minute wrap never reaches hours.
  bcd2_counter #(.MAX(HOUR_MAX), .RST_VAL(8'h00)) u_hours (
    .CLK100MHZ (CLK100MHZ),
    .Reset     (Reset),
    .inc       ((!alarm_set && inc_hour) || (secs_wrap && mins_wrap)),
    .clr       (1'b0),
    .value     (hours),
    .nxt       (hours_nxt),
    .carry     (hours_wrap)
  );

  bcd2_counter #(.MAX(MIN_MAX), .RST_VAL(ALARM_DEFAULT_MM)) u_al_mm (
    .CLK100MHZ (CLK100MHZ),
    .Reset     (Reset),
    .inc       (alarm_set && inc_min),
    .clr       (1'b0),
    .value     (al_mm),
    .nxt       (al_mm_nxt),
    .carry     (al_mm_wrap)
  );

  bcd2_counter #(.MAX(HOUR_MAX), .RST_VAL(ALARM_DEFAULT_HH)) u_al_hh (
    .CLK100MHZ (CLK100MHZ),
    .Reset     (Reset),
    .inc       (alarm_set && inc_hour),
    .clr       (1'b0),
    .value     (al_hh),
    .nxt       (al_hh_nxt),
    .carry     (al_hh_wrap)
  );

  // Match only on a real tick rolling into second 00, so manual edits never trigger.
  assign alarm_hit    = secs_wrap && (mins_nxt == al_mm) && (hours_nxt == al_hh);
  assign ring_cnt_inc = ring_cnt + 8'd1;

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      alarm_state <= IDLE;
      ring_cnt    <= 8'd0;
    end else begin
      alarm_state <= state_nxt;
      ring_cnt    <= ring_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = alarm_state;
    ring_cnt_nxt = ring_cnt;
    case (alarm_state)
      IDLE: begin
        if (alarm_arm)
          state_nxt = ARMED;
      end
      ARMED: begin
        if (!alarm_arm) begin
          state_nxt = IDLE;
        end else if (alarm_hit) begin
          state_nxt    = RINGING;
          ring_cnt_nxt = 8'd0;
        end
      end
      RINGING: begin
        if (!alarm_arm) begin
          state_nxt = IDLE;
        end else if (alarm_ack) begin
          state_nxt = ARMED;
        end else if (tick) begin
          ring_cnt_nxt = ring_cnt_inc;
          if (ring_cnt_inc == 8'(RING_SECS))
            state_nxt = ARMED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign alarm_ring = (alarm_state == RINGING);

  assign src_hh = alarm_set ? al_hh : hours;
  assign src_mm = alarm_set ? al_mm : mins;
  assign src_ss = alarm_set ? 8'h00 : secs;
  assign h12    = to_12h(src_hh);

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      hours_bcd <= 8'h00;
      mins_bcd  <= 8'h00;
      secs_bcd  <= 8'h00;
      pm        <= 1'b0;
    end else begin
      hours_bcd <= mode_12h ? h12[7:0] : src_hh;
      mins_bcd  <= src_mm;
      secs_bcd  <= src_ss;
      pm        <= h12[8];
    end
  end

endmodule

// File: tb/tb_wall_clock_core.sv
// Directed bench for wall_clock_core with a 4-cycle second and 3-second ring timeout.
module tb_wall_clock_core;
  import clock_pkg::*;

  logic       CLK100MHZ;
  logic       Reset;
  logic       run_en, mode_12h, inc_min, inc_hour;
  logic       alarm_set, alarm_arm, alarm_ack;
  logic [7:0] hours_bcd, mins_bcd, secs_bcd;
  logic       pm, sec_pulse, alarm_ring;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic seen_ring;

  wall_clock_core #(
    .TICKS_PER_SEC    (4),
    .RING_SECS        (3),
    .ALARM_DEFAULT_HH (8'h00),
    .ALARM_DEFAULT_MM (8'h00)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .Reset      (Reset),
    .run_en     (run_en),
    .mode_12h   (mode_12h),
    .inc_min    (inc_min),
    .inc_hour   (inc_hour),
    .alarm_set  (alarm_set),
    .alarm_arm  (alarm_arm),
    .alarm_ack  (alarm_ack),
    .hours_bcd  (hours_bcd),
    .mins_bcd   (mins_bcd),
    .secs_bcd   (secs_bcd),
    .pm         (pm),
    .sec_pulse  (sec_pulse),
    .alarm_ring (alarm_ring)
  );

  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                            input logic [7:0] ss);
    check({tag, ".hh"}, hours_bcd, hh);
    check({tag, ".mm"}, mins_bcd, mm);
    check({tag, ".ss"}, secs_bcd, ss);
  endtask

  task automatic cycle();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      inc_min = 1'b1;
      cycle();
    end
    inc_min = 1'b0;
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin
      inc_hour = 1'b1;
      cycle();
    end
    inc_hour = 1'b0;
  endtask

  // Runs exactly n seconds from prescaler 0, then one idle cycle so the display catches up.
  task automatic run_ticks(input int n);
    run_en = 1'b1;
    repeat (4 * n) begin
      cycle();
      if (sec_pulse) pulses++;
    end
    run_en = 1'b0;
    cycle();
  endtask

  task automatic wait_ring(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !alarm_ring; i++) cycle();
    check(tag, alarm_ring, 1'b1);
  endtask

  initial begin
    Reset = 1'b1;
    run_en = 1'b0; mode_12h = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    alarm_set = 1'b0; alarm_arm = 1'b0; alarm_ack = 1'b0;

    #2;
    check_disp("rst", 8'h00, 8'h00, 8'h00);
    check("rst.pm", pm, 1'b0);
    check("rst.sec_pulse", sec_pulse, 1'b0);
    check("rst.ring", alarm_ring, 1'b0);
    cycle();
    cycle();
    Reset = 1'b0;

    // 60 seconds of free running
    pulses = 0;
    run_ticks(60);
    check("t1.pulses", pulses, 60);
    check_disp("t1.one_min", 8'h00, 8'h01, 8'h00);

    // 23:59:59 -> 00:00:00
    pulse_hour(23);
    pulse_min(58);
    run_ticks(59);
    check_disp("t1.preload", 8'h23, 8'h59, 8'h59);
    pulses = 0;
    run_ticks(1);
    check("t1.wrap_pulse", pulses, 1);
    check_disp("t1.wrap", 8'h00, 8'h00, 8'h00);

    // Minute edit mid-second restarts the second
    run_ticks(37);
    check_disp("t2.37s", 8'h00, 8'h00, 8'h37);
    run_en = 1'b1;
    cycle();
    cycle();
    inc_min = 1'b1;
    cycle();
    inc_min = 1'b0;
    check("t2.sp0", sec_pulse, 1'b0);
    cycle();
    check_disp("t2.edit", 8'h00, 8'h01, 8'h00);
    check("t2.sp1", sec_pulse, 1'b0);
    cycle();
    check("t2.sp2", sec_pulse, 1'b0);
    cycle();
    check("t2.sp3", sec_pulse, 1'b1);
    run_en = 1'b0;
    cycle();

    // Manual minute wrap does not carry into hours
    pulse_hour(5);
    pulse_min(58);
    cycle();
    check_disp("t2.m59", 8'h05, 8'h59, 8'h00);
    pulse_min(1);
    cycle();
    check_disp("t2.mwrap", 8'h05, 8'h00, 8'h00);

    // Edit coincident with the tick wins
    run_en = 1'b1;
    repeat (3) cycle();
    check("t2.coinc_sp", sec_pulse, 1'b1);
    inc_min = 1'b1;
    cycle();
    inc_min = 1'b0;
    run_en = 1'b0;
    cycle();
    check_disp("t2.coinc", 8'h05, 8'h01, 8'h00);

    // 12-hour mapping
    pulse_hour(19);
    mode_12h = 1'b1;
    cycle();
    check("t3.h00", hours_bcd, 8'h12);
    check("t3.h00.pm", pm, 1'b0);
    pulse_hour(12);
    cycle();
    check("t3.h12", hours_bcd, 8'h12);
    check("t3.h12.pm", pm, 1'b1);
    pulse_hour(1);
    cycle();
    check("t3.h13", hours_bcd, 8'h01);
    check("t3.h13.pm", pm, 1'b1);
    pulse_hour(10);
    cycle();
    check("t3.h23", hours_bcd, 8'h11);
    check("t3.h23.pm", pm, 1'b1);
    mode_12h = 1'b0;
    check("t3.toggle_hold", hours_bcd, 8'h11);
    cycle();
    check("t3.toggle", hours_bcd, 8'h23);
    check("t3.toggle.pm", pm, 1'b1);

    // Alarm at 07:00 fires on the 07:00:00 tick
    alarm_set = 1'b1;
    cycle();
    check_disp("t4.al_default", 8'h00, 8'h00, 8'h00);
    pulse_hour(7);
    cycle();
    check_disp("t4.al_set", 8'h07, 8'h00, 8'h00);
    alarm_arm = 1'b1;
    alarm_set = 1'b0;
    pulse_hour(7);
    pulse_min(58);
    run_ticks(58);
    check_disp("t4.pre", 8'h06, 8'h59, 8'h58);
    check("t4.pre.ring", alarm_ring, 1'b0);
    run_en = 1'b1;
    repeat (7) cycle();
    check("t4.match_sp", sec_pulse, 1'b1);
    check("t4.match_ring0", alarm_ring, 1'b0);
    cycle();
    check("t4.ring", alarm_ring, 1'b1);
    alarm_ack = 1'b1;
    cycle();
    alarm_ack = 1'b0;
    check("t4.ack", alarm_ring, 1'b0);
    seen_ring = 1'b0;
    repeat (236) begin
      cycle();
      if (alarm_ring) seen_ring = 1'b1;
    end
    check("t4.no_retrigger", seen_ring, 1'b0);
    run_en = 1'b0;
    cycle();
    check_disp("t4.end", 8'h07, 8'h00, 8'h59);

    // Ring timeout after 3 seconds without ack
    alarm_set = 1'b1;
    pulse_min(1);
    alarm_set = 1'b0;
    run_en = 1'b1;
    cycle();
    cycle();
    cycle();
    check("t5.ring", alarm_ring, 1'b1);
    repeat (11) cycle();
    check("t5.third_sp", sec_pulse, 1'b1);
    check("t5.still_ring", alarm_ring, 1'b1);
    cycle();
    check("t5.timeout", alarm_ring, 1'b0);

    // Disarm while ringing goes straight to IDLE
    run_en = 1'b0;
    alarm_set = 1'b1;
    pulse_min(1);
    alarm_set = 1'b0;
    run_en = 1'b1;
    wait_ring("t5.ring2", 300);
    alarm_arm = 1'b0;
    cycle();
    check("t5.disarm", alarm_ring, 1'b0);
    check("t5.idle", dut.alarm_state, IDLE);

    // Asynchronous reset mid-ring and mid-prescale
    alarm_arm = 1'b1;
    alarm_set = 1'b1;
    pulse_min(1);
    alarm_set = 1'b0;
    wait_ring("t6.ring", 300);
    cycle();
    cycle();
    #3;
    Reset = 1'b1;
    #1;
    check_disp("t6.async", 8'h00, 8'h00, 8'h00);
    check("t6.async.pm", pm, 1'b0);
    check("t6.async.sp", sec_pulse, 1'b0);
    check("t6.async.ring", alarm_ring, 1'b0);
    cycle();
    Reset = 1'b0;
    cycle();
    cycle();
    check("t6.presc_cleared", sec_pulse, 1'b0);
    cycle();
    check("t6.first_sp", sec_pulse, 1'b1);
    run_en = 1'b0;
    cycle();
    check_disp("t6.time", 8'h00, 8'h00, 8'h00);
    alarm_set = 1'b1;
    cycle();
    check_disp("t6.alarm", 8'h00, 8'h00, 8'h00);
    check("t6.ring_after", alarm_ring, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wall_clock_core.md
Name: wall_clock_core

Overview:
Parameterised time-of-day engine for the board clock: seconds/minutes/hours BCD counters with a configurable tick prescaler, run/hold, manual set, 12/24-hour display mode and one armed alarm with acknowledge and timeout. It sits between the Debounce/Delay_Reset front end and SS_Driver/LED logic. Button inputs arrive as debounced single-cycle pulses. Outputs are BCD digit pairs ready for the display driver.

Parameters:
TICKS_PER_SEC, 100000000, CLK100MHZ cycles per second tick (reduced in simulation); minimum 2.
RING_SECS, 60, seconds alarm_ring stays high without acknowledge; 1..255.
ALARM_DEFAULT_HH, 8'h00, BCD alarm hour loaded at reset.
ALARM_DEFAULT_MM, 8'h00, BCD alarm minute loaded at reset.

Ports:
CLK100MHZ  in  1  system clock
Reset  in  1  asynchronous, active-high reset
run_en  in  1  level; 1 = time advances, 0 = prescaler and time hold
mode_12h  in  1  level; 1 = 12-hour display, 0 = 24-hour display
inc_min  in  1  pulse; increment minutes of the edit target
inc_hour  in  1  pulse; increment hours of the edit target
alarm_set  in  1  level; 1 = edit/display alarm, 0 = edit/display time
alarm_arm  in  1  level; alarm enable
alarm_ack  in  1  pulse; silence ringing alarm
hours_bcd  out  8  displayed hour {tens,units}
mins_bcd  out  8  displayed minute
secs_bcd  out  8  displayed second (8'h00 while alarm_set=1)
pm  out  1  1 when displayed hour >= 12 (24h basis), either mode
sec_pulse  out  1  one-cycle strobe per second tick
alarm_ring  out  1  alarm active

Behaviour:
- Reset (async assert, sync release): prescaler 0; time 00:00:00; alarm = ALARM_DEFAULT_HH:MM; FSM IDLE; all outputs 0.
- Prescaler counts 0..TICKS_PER_SEC-1 while run_en=1; the cycle at terminal count asserts sec_pulse and wraps to 0. run_en=0: prescaler frozen, no sec_pulse.
- Tick: secs +1 BCD; 59->00 carries to mins; mins 59->00 carries to hours; hours 23->00. All in one cycle.
- Time is stored in 24h BCD. Units digit wraps 9->0 with tens +1. Illegal BCD is never produced.
- Manual edit, alarm_set=0: inc_min gives mins +1 with wrap 59->00 and no hour carry. inc_hour gives hours +1 with wrap 23->00. Either pulse clears secs to 00 and the prescaler to 0. A coincident tick is discarded that cycle. inc_min and inc_hour in the same cycle both apply.
- Manual edit, alarm_set=1: pulses edit the alarm registers with the same wrap rules. Time keeps running and ticks are unaffected.
- Display path is registered, 1-cycle latency from internal state.
  - Source is time, or alarm with secs 00, selected by alarm_set.
  - 12h mapping: h=0 -> 12, pm=0; 1..11 -> h, pm=0; 12 -> 12, pm=1; 13..23 -> h-12, pm=1.
  - After reset the display shows 00 until the first clock edge, then the mapped value (12 with mode_12h=1).
- Alarm FSM (registered; alarm_ring = state==RINGING):
  - IDLE: alarm_arm=1 -> ARMED.
  - ARMED: on a tick producing secs==00 with hh:mm == alarm -> RINGING, ring counter = 0. A manual edit landing on the alarm time does not trigger. alarm_arm=0 -> IDLE.
  - RINGING: alarm_ack -> ARMED. Ring counter increments per tick; reaching RING_SECS -> ARMED. alarm_arm=0 -> IDLE. Priority: arm=0 > ack > timeout.
  - ARMED after ring: no retrigger until the next matching 00-second tick, 24 h later.
  - alarm_ring rises the cycle after the matching sec_pulse.
- Reset mid-operation: all state returns to reset values immediately, including ringing.

Decomposition:
- Package clock_pkg:
  - alarm state enum {IDLE, ARMED, RINGING}
  - BCD limit constants (8'h59, 8'h23)
  - function to_12h(hh) returning {pm, hh12}
- Sub-module bcd2_counter:
  - two-digit BCD register with inc, clr, parameter MAX, carry-out on wrap
  - instantiated 5x: secs, mins, hours, alarm mins, alarm hours

Test Plan (TICKS_PER_SEC=4, RING_SECS=3):
1. Reset, run_en=1, 240 cycles -> 60 sec_pulses, display 00:01:00. Preload 23:59:59, one tick -> 00:00:00.
2. At 00:00:37, pulse inc_min -> 00:01:00 and next sec_pulse 4 cycles later. At mins 59, inc_min -> 00 with hour unchanged. inc_min coincident with sec_pulse -> secs 00, tick lost.
3. mode_12h=1: hour 00 -> 8'h12 pm=0; 12 -> 8'h12 pm=1; 13 -> 8'h01 pm=1; 23 -> 8'h11 pm=1. Toggle mode -> output changes after 1 cycle.
4. alarm_set=1, set alarm 07:00, arm. Time 06:59:58, run -> alarm_ring=1 the cycle after the 07:00:00 tick. alarm_ack -> 0 next cycle, no retrigger at 07:00:01..07:00:59.
5. Ringing, no ack -> alarm_ring drops after 3 sec_pulses. Separately, alarm_arm=0 while ringing -> 0 next cycle, FSM IDLE.
6. Assert Reset mid-ring and mid-prescale, asynchronously between edges -> all outputs 0 before the next edge. After release, time 00:00:00 and alarm at ALARM_DEFAULT.
